alu_exec_unit: RTL and testbench

- Execute-stage arithmetic block for the single-cycle MIPS datapath.
- Contains three parts:
  - a registered ALU-control decoder that turns the 6-bit `alu_op` from the main control unit into a 4-bit ALU function code;
  - a combinational 32-bit MIPS ALU with zero, carry-out and signed-overflow flags;
  - an independent combinational 32-bit adder, used for PC+4 and branch-target computation.

---
 rtl/alu_exec_unit.sv | 81 ++++++++
 tb/tb_alu_exec_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS execute stage with a registered ALU-control decode, a flagged ALU and an independent PC/branch adder.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter logic [3:0] RESET_CTL = 4'b0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       alu_op,
  output logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] alu_res,
  output logic             zero,
  output logic             cout,
  output logic             ovf,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  output logic [WIDTH-1:0] add_sum
);
  localparam int M = WIDTH - 1;
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_XOR = 4'b0011;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  logic [3:0]     w_ctl_next;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_add_ovf;
  logic           w_sub_ovf;
  logic           w_slt;
  // 6'h23 appears only under ADD: lw takes priority over subu
  always_comb begin
    w_ctl_next = CTL_ADD;
    case (alu_op)
      6'h22, 6'h04, 6'h05: w_ctl_next = CTL_SUB;
      6'h24, 6'h0C:        w_ctl_next = CTL_AND;
      6'h25, 6'h0D:        w_ctl_next = CTL_OR;
      6'h26, 6'h0E:        w_ctl_next = CTL_XOR;
      6'h27:               w_ctl_next = CTL_NOR;
      6'h2A, 6'h0A:        w_ctl_next = CTL_SLT;
      default:             w_ctl_next = CTL_ADD;
    endcase
  end
  always_ff @(posedge clk)
    alu_ctl <= reset ? RESET_CTL : w_ctl_next;
  assign w_sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign w_diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_add_ovf = (a[M] == b[M]) && (w_sum[M] != a[M]);
  assign w_sub_ovf = (a[M] != b[M]) && (w_diff[M] != a[M]);
  // sign of the difference corrected by overflow gives a true signed compare
  assign w_slt     = w_diff[M] ^ w_sub_ovf;
  always_comb begin
    alu_res = '0;
    cout    = 1'b0;
    ovf     = 1'b0;
    case (alu_ctl)
      CTL_ADD: begin
        alu_res = w_sum[M:0];
        cout    = w_sum[WIDTH];
        ovf     = w_add_ovf;
      end
      CTL_SUB: begin
        alu_res = w_diff[M:0];
        cout    = w_diff[WIDTH];
        ovf     = w_sub_ovf;
      end
      CTL_AND: alu_res = a & b;
      CTL_OR:  alu_res = a | b;
      CTL_XOR: alu_res = a ^ b;
      CTL_NOR: alu_res = ~(a | b);
      CTL_SLT: alu_res = {{M{1'b0}}, w_slt};
      default: alu_res = '0;
    endcase
  end
  assign zero    = (alu_res == '0);
  assign add_sum = add_a + add_b;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed expectations for alu_exec_unit.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  alu_op;
  logic [3:0]  alu_ctl;
  logic [31:0] a, b, alu_res, add_a, add_b, add_sum;
  logic        cin, zero, cout, ovf;
  int          checks = 0;
  int          errors = 0;

  alu_exec_unit dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .alu_ctl(alu_ctl),
    .a(a), .b(b), .cin(cin), .alu_res(alu_res), .zero(zero), .cout(cout), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [5:0] o);
    alu_op = o;
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic z, input logic c, input logic v);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, c});
    check({tag, ".ovf"},  {31'd0, ovf},  {31'd0, v});
  endtask

  initial begin
    reset = 1'b1; alu_op = 6'h22; a = '0; b = '0; cin = 1'b0; add_a = '0; add_b = '0;
    @(posedge clk); #1;
    check("reset_ctl", {28'd0, alu_ctl}, 32'h2);
    reset = 1'b0;
    #2;
    check("ctl_before_edge", {28'd0, alu_ctl}, 32'h2);
    @(posedge clk); #1;
    check("ctl_sub_after_release", {28'd0, alu_ctl}, 32'h6);

    set_op(6'h20);
    check("add_ctl", {28'd0, alu_ctl}, 32'h2);
    a = 32'h7FFFFFFF; b = 32'h1; #1;
    check("add_ovf_res", alu_res, 32'h80000000);
    flags("add_ovf", 1'b0, 1'b0, 1'b1);
    a = 32'hFFFFFFFF; #1;
    check("add_wrap_res", alu_res, 32'h0);
    flags("add_wrap", 1'b1, 1'b1, 1'b0);
    a = 32'd10; b = 32'd20; cin = 1'b1; #1;
    check("add_cin", alu_res, 32'd31);

    set_op(6'h04);
    check("beq_ctl", {28'd0, alu_ctl}, 32'h6);
    a = 32'h1234; b = 32'h1234; #1;
    check("beq_res", alu_res, 32'h0);
    flags("beq", 1'b1, 1'b1, 1'b0);
    a = 32'h80000000; b = 32'h1; #1;
    check("sub_ovf_res", alu_res, 32'h7FFFFFFF);
    flags("sub_ovf", 1'b0, 1'b1, 1'b1);
    cin = 1'b0; a = 32'd3; b = 32'd5; #1;
    check("sub_borrow_res", alu_res, 32'hFFFFFFFE);
    flags("sub_borrow", 1'b0, 1'b0, 1'b0);

    set_op(6'h2A);
    check("slt_ctl", {28'd0, alu_ctl}, 32'h7);
    a = 32'hFFFFFFFF; b = 32'h1; #1;
    check("slt_neg", alu_res, 32'h1);
    a = 32'h80000000; b = 32'h7FFFFFFF; #1;
    check("slt_ovf_edge", alu_res, 32'h1);
    flags("slt_ovf_edge", 1'b0, 1'b0, 1'b0);
    a = 32'h7FFFFFFF; b = 32'h80000000; #1;
    check("slt_ovf_edge_rev", alu_res, 32'h0);
    a = 32'd5; b = 32'd5; #1;
    check("slt_eq", alu_res, 32'h0);
    check("slt_eq_zero", {31'd0, zero}, 32'h1);

    a = 32'hF0F0F0F0; b = 32'h0FF00FF0;
    set_op(6'h24);
    check("and", alu_res, 32'h00F000F0);
    flags("and", 1'b0, 1'b0, 1'b0);
    set_op(6'h25);
    check("or", alu_res, 32'hFFF0FFF0);
    flags("or", 1'b0, 1'b0, 1'b0);
    set_op(6'h26);
    check("xor", alu_res, 32'hFF00FF00);
    flags("xor", 1'b0, 1'b0, 1'b0);
    set_op(6'h27);
    check("nor", alu_res, 32'h000F000F);
    flags("nor", 1'b0, 1'b0, 1'b0);

    set_op(6'h0C); check("andi_ctl", {28'd0, alu_ctl}, 32'h0);
    set_op(6'h0D); check("ori_ctl",  {28'd0, alu_ctl}, 32'h1);
    set_op(6'h0E); check("xori_ctl", {28'd0, alu_ctl}, 32'h3);
    set_op(6'h0A); check("slti_ctl", {28'd0, alu_ctl}, 32'h7);
    set_op(6'h05); check("bne_ctl",  {28'd0, alu_ctl}, 32'h6);
    set_op(6'h23); check("lw_ctl",   {28'd0, alu_ctl}, 32'h2);
    set_op(6'h22); check("sub_ctl",  {28'd0, alu_ctl}, 32'h6);
    set_op(6'h2B); check("sw_ctl",   {28'd0, alu_ctl}, 32'h2);
    set_op(6'h22);
    set_op(6'h3F); check("default_ctl", {28'd0, alu_ctl}, 32'h2);

    set_op(6'h24);
    reset = 1'b1;
    set_op(6'h25);
    check("mid_reset_ctl", {28'd0, alu_ctl}, 32'h2);
    reset = 1'b0;

    add_a = 32'h00400000; add_b = 32'd4; #1;
    check("pc_plus4", add_sum, 32'h00400004);
    add_a = 32'hFFFFFFFC; add_b = 32'd8; #1;
    check("adder_wrap", add_sum, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
